// File: rtl/irq_agg3_pkg.sv
// Shared constants, FSM state type and priority encoder for the three-channel
// interrupt aggregator.
package irq_agg3_pkg;

    localparam int NUM_CH = 3;
    localparam int VEC_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        HOLDOFF
    } state_t;

    // Lowest set index wins, so channel 0 has the highest priority.
    function automatic logic [VEC_W-1:0] prio_enc(input logic [NUM_CH-1:0] req);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) idx = VEC_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_aggregator3_if.sv
// Request/mask/acknowledge bundle between the request side and the aggregator.
interface irq_aggregator3_if;
    import irq_agg3_pkg::*;

    logic [NUM_CH-1:0] req_i;
    logic [NUM_CH-1:0] mask_i;
    logic              ack_i;
    logic              irq_o;
    logic              vec_valid_o;
    logic [VEC_W-1:0]  vec_o;
    logic [NUM_CH-1:0] pending_o;

    modport master (
        output req_i, mask_i, ack_i,
        input  irq_o, vec_valid_o, vec_o, pending_o
    );

    modport slave (
        input  req_i, mask_i, ack_i,
        output irq_o, vec_valid_o, vec_o, pending_o
    );

endinterface

// File: rtl/irq_sync_edge.sv
// One request channel: synchroniser, optional debounce filter and rising-edge pulse.
// The filter is built only when IRQ_AGG3_DEBOUNCE_EN is defined.
module irq_sync_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic edge_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("irq_sync_edge: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("irq_sync_edge: DEBOUNCE_CYCLES must be at least 1");
    end

    // Edges stay suppressed until the pipeline holds real samples, so a line
    // held high through reset release never looks like a new request.
    localparam int PRIME = SYNC_STAGES + 2;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PRIME-1:0]       prime_q, prime_d;
    logic                   req_d_q, req_d_d;
    logic                   req_s, level, primed;

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign primed = prime_q[PRIME-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], req_i};
        prime_d = {prime_q[PRIME-2:0], 1'b1};
        req_d_d = level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            req_d_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
            req_d_q <= req_d_d;
        end
    end

`ifdef IRQ_AGG3_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             flt_q, flt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        flt_d = flt_q;
        cnt_d = '0;
        if (!primed) begin
            flt_d = req_s;
        end else if (req_s != flt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) flt_d = req_s;
            else                                      cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            flt_q <= flt_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = flt_q;
`else
    assign level = req_s;
`endif

    assign edge_o = level & ~req_d_q & primed;

endmodule

// File: rtl/irq_aggregator3.sv
// Three-channel interrupt aggregator: sticky pending bits, mask, priority vector
// and ack handshake. IRQ_AGG3_DEBOUNCE_EN adds a per-channel debounce filter.
module irq_aggregator3
    import irq_agg3_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    irq_aggregator3_if.slave bus
);

    logic [NUM_CH-1:0] edge_w;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] active, vec_sel;

    state_t           state_q;
    logic [VEC_W-1:0] vec_q;
    logic             irq_q, vld_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        irq_sync_edge #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .req_i (bus.req_i[i]),
            .edge_o(edge_w[i])
        );
    end

    assign active  = pending_q & ~bus.mask_i;
    assign vec_sel = NUM_CH'(1) << vec_q;

    // The set term is applied last so a new edge beats a same-cycle ack.
    always_comb begin
        pending_d = pending_q;
        if (state_q == PRESENT && bus.ack_i) pending_d = pending_d & ~vec_sel;
        pending_d = pending_d | edge_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            irq_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|active) begin
                        vec_q   <= prio_enc(active);
                        irq_q   <= 1'b1;
                        vld_q   <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack_i) begin
                        irq_q   <= 1'b0;
                        vld_q   <= 1'b0;
                        state_q <= HOLDOFF;
                    end else if (|(bus.mask_i & vec_sel)) begin
                        irq_q   <= 1'b0;
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                HOLDOFF: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.irq_o       = irq_q;
    assign bus.vec_valid_o = vld_q;
    assign bus.vec_o       = vec_q;
    assign bus.pending_o   = pending_q;

endmodule

// File: tb/tb_irq_aggregator3.sv
// Scoreboard bench for irq_aggregator3: directed scenarios plus randomized rounds.
// Define IRQ_AGG3_DEBOUNCE_EN to exercise the debounce build.
module tb_irq_aggregator3;
    import irq_agg3_pkg::*;

`ifdef IRQ_AGG3_DEBOUNCE_EN
    localparam int LAT_EXTRA = 4;
`else
    localparam int LAT_EXTRA = 0;
`endif
    localparam int HOLD = LAT_EXTRA + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic ack_auto, ack_man, auto_ack_en;

    always #5 clk = ~clk;

    irq_aggregator3_if bus();
    assign bus.ack_i = ack_auto | ack_man;

    irq_aggregator3 #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] mask);
        bus.req_i  = req;
        bus.mask_i = mask;
    endtask

    task automatic ackOnce();
        ack_man = 1'b1;
        step(1);
        ack_man = 1'b0;
    endtask

    task automatic waitValid(input string name, input int max_cycles);
        int k;
        k = 0;
        while (!bus.vec_valid_o && k < max_cycles) begin
            step(1);
            k++;
        end
        checkOutput(name, bus.vec_valid_o, 1);
    endtask

    // Randomly acknowledges presented vectors during the random phase.
    initial begin
        ack_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack_auto = auto_ack_en && bus.vec_valid_o && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every new presentation pops the next expected channel.
    initial begin : monitor
        logic prev_valid;
        int   hold_cnt;
        int   exp_v;
        prev_valid = 1'b0;
        hold_cnt   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                hold_cnt   = 0;
            end else begin
                if (hold_cnt > 0) begin
                    checkOutput("holdoff_irq_low", bus.irq_o, 0);
                    hold_cnt--;
                end
                if (bus.vec_valid_o && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_vector: actual=%0d required=none at %0t",
                                 bus.vec_o, $time);
                    end else begin
                        exp_v = exp_q.pop_front();
                        checkOutput("vector", bus.vec_o, exp_v);
                    end
                    checkOutput("present_irq", bus.irq_o, 1);
                    checkOutput("present_pending", bus.pending_o[bus.vec_o], 1);
                end
                if (bus.vec_valid_o && bus.ack_i) hold_cnt = 2;
                prev_valid = bus.vec_valid_o;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] pat;
        int         hold;
        int         k;

        rst_n       = 1'b0;
        ack_man     = 1'b0;
        auto_ack_en = 1'b0;
        applyStimulus(3'b010, 3'b000);
        step(3);
        checkOutput("reset_irq", bus.irq_o, 0);
        checkOutput("reset_valid", bus.vec_valid_o, 0);
        checkOutput("reset_vec", bus.vec_o, 0);
        checkOutput("reset_pending", bus.pending_o, 0);

        // Request held high through reset release is not an edge.
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checkOutput("held_req_irq", bus.irq_o, 0);
            checkOutput("held_req_pending", bus.pending_o, 0);
        end
        applyStimulus(3'b000, 3'b000);
        step(6 + LAT_EXTRA);

        // Latency and ack on channel 2.
        exp_q.push_back(2);
        applyStimulus(3'b100, 3'b000);
        step(3 + LAT_EXTRA);
        checkOutput("lat_pending", bus.pending_o, 3'b100);
        checkOutput("lat_irq_early", bus.irq_o, 0);
        applyStimulus(3'b000, 3'b000);
        step(1);
        checkOutput("lat_irq", bus.irq_o, 1);
        checkOutput("lat_valid", bus.vec_valid_o, 1);
        checkOutput("lat_vec", bus.vec_o, 2);
        ackOnce();
        checkOutput("ack_pending_clear", bus.pending_o, 0);
        checkOutput("ack_irq_low", bus.irq_o, 0);
        step(4);
        checkOutput("ack_irq_stays_low", bus.irq_o, 0);

        // Simultaneous channels 0 and 1: priority order.
        exp_q.push_back(0);
        exp_q.push_back(1);
        applyStimulus(3'b011, 3'b000);
        step(HOLD);
        applyStimulus(3'b000, 3'b000);
        waitValid("prio_first_valid", 20);
        checkOutput("prio_first_vec", bus.vec_o, 0);
        ackOnce();
        checkOutput("prio_holdoff_irq", bus.irq_o, 0);
        step(1);
        checkOutput("prio_idle_irq", bus.irq_o, 0);
        step(1);
        checkOutput("prio_second_irq", bus.irq_o, 1);
        checkOutput("prio_second_vec", bus.vec_o, 1);
        ackOnce();
        step(4);

        // Masked channel still latches pending.
        applyStimulus(3'b000, 3'b001);
        applyStimulus(3'b001, 3'b001);
        step(HOLD);
        applyStimulus(3'b000, 3'b001);
        step(6 + LAT_EXTRA);
        checkOutput("mask_pending", bus.pending_o, 3'b001);
        checkOutput("mask_irq", bus.irq_o, 0);
        exp_q.push_back(0);
        applyStimulus(3'b000, 3'b000);
        step(1);
        checkOutput("unmask_irq", bus.irq_o, 1);
        checkOutput("unmask_vec", bus.vec_o, 0);
        ackOnce();
        step(4);

        // New edge on channel 2 landing in its own ack cycle: set wins.
        exp_q.push_back(2);
        applyStimulus(3'b100, 3'b000);
        step(HOLD);
        applyStimulus(3'b000, 3'b000);
        waitValid("setwin_first_valid", 20);
        step(4 + LAT_EXTRA);
        exp_q.push_back(2);
        applyStimulus(3'b100, 3'b000);
        step(2 + LAT_EXTRA);
        ack_man = 1'b1;
        step(1);
        ack_man = 1'b0;
        checkOutput("setwin_pending", bus.pending_o, 3'b100);
        checkOutput("setwin_irq_low", bus.irq_o, 0);
        step(1);
        checkOutput("setwin_idle_irq", bus.irq_o, 0);
        step(1);
        checkOutput("setwin_represent_irq", bus.irq_o, 1);
        checkOutput("setwin_represent_vec", bus.vec_o, 2);
        applyStimulus(3'b000, 3'b000);
        ackOnce();
        step(4 + LAT_EXTRA);

        // Repeated edges on a pending channel collapse into one.
        exp_q.push_back(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b010, 3'b000);
            step(HOLD);
            applyStimulus(3'b000, 3'b000);
            step(HOLD);
        end
        step(4 + LAT_EXTRA);
        checkOutput("collapse_pending", bus.pending_o, 3'b010);
        checkOutput("collapse_vec", bus.vec_o, 1);
        ackOnce();
        step(10 + LAT_EXTRA);
        checkOutput("collapse_cleared", bus.pending_o, 0);
        checkOutput("collapse_irq", bus.irq_o, 0);

        // Higher priority arrival during PRESENT does not preempt.
        exp_q.push_back(2);
        applyStimulus(3'b100, 3'b000);
        step(HOLD);
        applyStimulus(3'b000, 3'b000);
        waitValid("nopreempt_valid", 20);
        exp_q.push_back(0);
        applyStimulus(3'b001, 3'b000);
        step(HOLD);
        applyStimulus(3'b000, 3'b000);
        step(4 + LAT_EXTRA);
        checkOutput("nopreempt_vec", bus.vec_o, 2);
        checkOutput("nopreempt_pending", bus.pending_o, 3'b101);
        ackOnce();
        step(2);
        checkOutput("nopreempt_next_vec", bus.vec_o, 0);
        checkOutput("nopreempt_next_irq", bus.irq_o, 1);
        ackOnce();
        step(4);

        // Ack outside PRESENT is ignored; mask rising in PRESENT withdraws.
        applyStimulus(3'b000, 3'b010);
        applyStimulus(3'b010, 3'b010);
        step(HOLD);
        applyStimulus(3'b000, 3'b010);
        step(4 + LAT_EXTRA);
        ack_man = 1'b1;
        step(2);
        ack_man = 1'b0;
        checkOutput("idle_ack_pending", bus.pending_o, 3'b010);
        checkOutput("idle_ack_irq", bus.irq_o, 0);
        exp_q.push_back(1);
        applyStimulus(3'b000, 3'b000);
        step(1);
        checkOutput("withdraw_pre_vec", bus.vec_o, 1);
        applyStimulus(3'b000, 3'b010);
        step(1);
        checkOutput("withdraw_valid", bus.vec_valid_o, 0);
        checkOutput("withdraw_irq", bus.irq_o, 0);
        checkOutput("withdraw_pending", bus.pending_o, 3'b010);
        exp_q.push_back(1);
        applyStimulus(3'b000, 3'b000);
        step(1);
        checkOutput("withdraw_represent", bus.vec_valid_o, 1);
        ackOnce();
        step(4);

        // Reset in the middle of a presentation clears everything at once.
        exp_q.push_back(0);
        applyStimulus(3'b001, 3'b000);
        step(HOLD);
        applyStimulus(3'b000, 3'b000);
        waitValid("midreset_valid", 20);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_irq", bus.irq_o, 0);
        checkOutput("midreset_valid_low", bus.vec_valid_o, 0);
        checkOutput("midreset_pending", bus.pending_o, 0);
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(8 + LAT_EXTRA);

`ifdef IRQ_AGG3_DEBOUNCE_EN
        // A glitch shorter than the debounce window is filtered out.
        applyStimulus(3'b010, 3'b000);
        step(3);
        applyStimulus(3'b000, 3'b000);
        step(15);
        checkOutput("glitch_pending", bus.pending_o, 0);
        checkOutput("glitch_irq", bus.irq_o, 0);
        exp_q.push_back(1);
        applyStimulus(3'b010, 3'b000);
        step(6);
        applyStimulus(3'b000, 3'b000);
        step(4);
        checkOutput("debounce_pending", bus.pending_o, 3'b010);
        ackOnce();
        step(10);
`endif

        // Random rounds: all chosen channels rise together and drain in index order.
        auto_ack_en = 1'b1;
        for (int r = 0; r < 12; r++) begin
            pat  = 3'($urandom_range(1, 7));
            hold = $urandom_range(HOLD, HOLD + 3);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (pat[ch]) exp_q.push_back(ch);
            end
            applyStimulus(pat, 3'b000);
            step(hold);
            applyStimulus(3'b000, 3'b000);
            k = 0;
            while ((exp_q.size() != 0 || bus.vec_valid_o || bus.pending_o != 0) && k < 200) begin
                step(1);
                k++;
            end
            checkOutput("round_drained", bus.pending_o, 0);
            step(4 + LAT_EXTRA);
        end
        auto_ack_en = 1'b0;
        step(5);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
